// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window generator: FSM states and the
// default-width 3x3 window view used by downstream consumers.
package sobel_pkg;

  localparam int unsigned PIX_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StFlush
  } state_e;

  // Row-major: p0..p2 top row, p4 centre, p6..p8 bottom row.
  typedef struct packed {
    logic [PIX_W_DEFAULT-1:0] p0;
    logic [PIX_W_DEFAULT-1:0] p1;
    logic [PIX_W_DEFAULT-1:0] p2;
    logic [PIX_W_DEFAULT-1:0] p3;
    logic [PIX_W_DEFAULT-1:0] p4;
    logic [PIX_W_DEFAULT-1:0] p5;
    logic [PIX_W_DEFAULT-1:0] p6;
    logic [PIX_W_DEFAULT-1:0] p7;
    logic [PIX_W_DEFAULT-1:0] p8;
  } window_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed-length delay line built as a circular-pointer memory: dout is the
// value written DEPTH enabled cycles ago. Contents are never cleared.
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_q;

  // Read-before-write at the same slot gives exactly DEPTH steps of delay.
  assign dout = mem[ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to zero-padded 3x3 window stream, one window per
// input pixel, ordered by window centre.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 512,
  parameter int unsigned IMG_H = 512,
  parameter int unsigned PIX_W = PIX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPIX);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [CNT_W-1:0] CNT_W_IDX = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

  typedef logic [2:0][2:0][PIX_W-1:0] win_arr_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  win_arr_t         win_q, win_d, out_q, out_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             out_free, step, emit;
  logic [PIX_W-1:0] pix_eff, lb1_out, lb2_out;

  assign out_free = !valid_q || win_ready;
  assign in_ready = (state_q != StFlush) && out_free;
  assign step     = (state_q == StFlush) ? out_free : (in_valid && in_ready);
  assign emit     = step && (state_q != StFill);
  assign pix_eff  = (state_q == StFlush) ? '0 : pix_in;

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (step),
    .din  (pix_eff),
    .dout (lb1_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (step),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (step) begin
      unique case (state_q)
        StFill: begin
          if (cnt_q == CNT_W_IDX) state_d = StRun;
          cnt_d = cnt_q + 1'b1;
        end
        StRun: begin
          if (cnt_q == CNT_LAST) begin
            state_d = StFlush;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StFlush: begin
          // IMG_W+1 flush steps drain the last row and the final centre.
          if (cnt_q == CNT_W_IDX) begin
            state_d = StFill;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StFill;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (emit) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb2_out;
    win_d[1][2] = lb1_out;
    win_d[2][2] = pix_eff;

    // Masks also hide stale line-buffer data from a prior frame or reset.
    out_d = win_d;
    if (row_q == '0)      out_d[0] = '0;
    if (row_q == ROW_LAST) out_d[2] = '0;
    for (int r = 0; r < 3; r++) begin
      if (col_q == '0)      out_d[r][0] = '0;
      if (col_q == COL_LAST) out_d[r][2] = '0;
    end
    last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);

    valid_d = valid_q;
    if (emit)           valid_d = 1'b1;
    else if (win_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      if (step) win_q <= win_d;
      if (emit) begin
        out_q  <= out_d;
        last_q <= last_d;
      end
    end
  end

  assign p0        = out_q[0][0];
  assign p1        = out_q[0][1];
  assign p2        = out_q[0][2];
  assign p3        = out_q[1][0];
  assign p4        = out_q[1][1];
  assign p5        = out_q[1][2];
  assign p6        = out_q[2][0];
  assign p7        = out_q[2][1];
  assign p8        = out_q[2][2];
  assign win_valid = valid_q;
  assign win_last  = last_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image: ramp, backpressure,
// input gaps, back-to-back frames and mid-frame reset.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NWIN = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic       win_valid;
  logic       win_ready = 1'b1;
  logic       win_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_in   (pix_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p0       (p0),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p4       (p4),
    .p5       (p5),
    .p6       (p6),
    .p7       (p7),
    .p8       (p8),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_last (win_last)
  );

  window_t     mon_w;
  logic [72:0] cap[$];

  assign mon_w = {p0, p1, p2, p3, p4, p5, p6, p7, p8};

  // Handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) cap.push_back({mon_w, win_last});
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] exp_win(input int base, input int c);
    logic [71:0] pix;
    int r0, c0, rr, cc, val;
    pix = '0;
    r0  = c / W;
    c0  = c % W;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr  = r0 + dr;
        cc  = c0 + dc;
        val = 0;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) val = base + rr * W + cc + 1;
        pix = {pix[63:0], val[7:0]};
      end
    end
    return {pix, (c == NWIN - 1)};
  endfunction

  function automatic logic [72:0] lit(input int a, input int b, input int c, input int d,
                                      input int e, input int f, input int g, input int h,
                                      input int i, input bit last);
    return {a[7:0], b[7:0], c[7:0], d[7:0], e[7:0], f[7:0], g[7:0], h[7:0], i[7:0], last};
  endfunction

  task automatic run_frame(input int base, input bit gaps, input bit bp,
                           output int first_cyc, output int flush_cyc);
    int          idx;
    int          cyc;
    bit          held;
    logic [72:0] held_w;
    idx       = 0;
    cyc       = 0;
    held      = 1'b0;
    held_w    = '0;
    first_cyc = -1;
    flush_cyc = 0;
    cap.delete();
    while (cap.size() < NWIN && cyc < 600) begin
      @(posedge clk);
      #1;
      in_valid  = (idx < NWIN) && (!gaps || $urandom_range(0, 1) == 1);
      pix_in    = 8'(base + idx + 1);
      win_ready = !bp || (cyc % 4 == 0) || (cyc % 4 == 3);
      #3;
      if (held) chk("hold_stable", 80'({mon_w, win_last}), 80'(held_w));
      held = win_valid && !win_ready;
      if (held) begin
        held_w = {mon_w, win_last};
        chk("hold_in_ready", 80'(in_ready), 80'(0));
      end
      if (win_valid && first_cyc < 0) first_cyc = cyc;
      if (!in_ready && win_ready) flush_cyc++;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    win_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int base);
    chk("win_count", 80'(cap.size()), 80'(NWIN));
    chk("idle_valid", 80'(win_valid), 80'(0));
    for (int i = 0; i < NWIN; i++) begin
      if (i < cap.size()) chk($sformatf("win%0d_b%0d", i, base), 80'(cap[i]),
                              80'(exp_win(base, i)));
    end
  endtask

  int first_cyc, flush_cyc;

  initial begin
    // Reset state
    #12;
    chk("rst_outputs", 80'({mon_w, win_last, win_valid}), 80'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_valid", 80'(win_valid), 80'(0));

    // Continuous ramp frame
    run_frame(0, 1'b0, 1'b0, first_cyc, flush_cyc);
    check_frame(0);
    if (cap.size() == NWIN) begin
      chk("ramp_c0", 80'(cap[0]), 80'(lit(0, 0, 0, 0, 1, 2, 0, 5, 6, 1'b0)));
      chk("ramp_c5", 80'(cap[5]), 80'(lit(1, 2, 3, 5, 6, 7, 9, 10, 11, 1'b0)));
      chk("ramp_c15", 80'(cap[15]), 80'(lit(11, 12, 0, 15, 16, 0, 0, 0, 0, 1'b1)));
    end
    chk("first_latency", 80'(first_cyc), 80'(W + 2));
    chk("flush_cycles", 80'(flush_cyc), 80'(W + 1));

    // Backpressure 1-0-0-1
    run_frame(0, 1'b0, 1'b1, first_cyc, flush_cyc);
    check_frame(0);

    // 50% input gaps
    run_frame(0, 1'b1, 1'b0, first_cyc, flush_cyc);
    check_frame(0);

    // Back-to-back frames, second offset by 100
    run_frame(0, 1'b0, 1'b0, first_cyc, flush_cyc);
    check_frame(0);
    run_frame(100, 1'b0, 1'b0, first_cyc, flush_cyc);
    check_frame(100);
    if (cap.size() == NWIN)
      chk("b2b_c0", 80'(cap[0]), 80'(lit(0, 0, 0, 0, 101, 102, 0, 105, 106, 1'b0)));

    // Mid-frame reset after 7 accepts
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    win_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pix_in = 8'(i + 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 80'(win_valid), 80'(1));
    chk("pre_rst_win", 80'({mon_w, win_last}), 80'(exp_win(0, 1)));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 80'({mon_w, win_last, win_valid}), 80'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 80'(in_ready), 80'(1));
    run_frame(0, 1'b0, 1'b0, first_cyc, flush_cyc);
    check_frame(0);
    chk("post_rst_latency", 80'(first_cyc), 80'(W + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-3x3-window generator feeding the `sobel` datapath. It accepts one grayscale pixel per handshake in raster order and buffers two image lines. It emits one zero-padded 3x3 neighbourhood per input pixel, in raster order of the window centre, on ports `p0`..`p8`, which map directly onto the `sobel` pixel inputs. It replaces the file-driven window feed and makes the Sobel chain usable on a live pixel stream.

## Interface
Parameters:
- `IMG_W`, 512: image width in pixels; must be ≥ 3.
- `IMG_H`, 512: image height in pixels; must be ≥ 3.
- `PIX_W`, 8: pixel width in bits.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `pix_in`, input, `PIX_W`: input pixel, raster order.
- `in_valid`, input, 1: `pix_in` is valid.
- `in_ready`, output, 1: block accepts `pix_in` this cycle.
- `p0`..`p8`, output, `PIX_W` each: window, row-major. `p0`/`p1`/`p2` are the top row, `p4` is the centre, `p6`/`p7`/`p8` are the bottom row.
- `win_valid`, output, 1: window on `p0`..`p8` is valid.
- `win_ready`, input, 1: consumer takes the window.
- `win_last`, output, 1: window is centred on pixel (IMG_H-1, IMG_W-1).

## Operation
- **Step.**
  - A step is an input accept (`in_valid && in_ready`) in FILL or RUN.
  - A step is also any cycle in FLUSH where the output register is free (`!win_valid || win_ready`).
  - State changes only on steps.
- **in_ready** = (state != FLUSH) && (!win_valid || win_ready). This is combinational.
- **States:**
  - FILL: accepts linear pixel indices 0..IMG_W and emits nothing. Moves to RUN after accepting index IMG_W.
  - RUN: accepts indices IMG_W+1..IMG_W*IMG_H-1. Each accept emits one window. Moves to FLUSH after the last accept.
  - FLUSH: runs IMG_W+1 steps with input treated as 0. Each step emits one window. Returns to FILL after the last step, ready for the next frame.
- **Storage.**
  - Two line delays of IMG_W entries each.
  - 3x3 shift register: each step shifts the columns left and loads a new right column of {line2 out, line1 out, new pixel}.
- **Window centre.**
  - The window emitted on the step that accepts linear index k is centred on linear index k-IMG_W-1.
  - Output counters `out_row`/`out_col` track the centre and wrap col→row at IMG_W-1 and row→0 at IMG_H-1.
- **Padding masks,** applied when loading the output register:
  - `out_row`==0 → `p0`,`p1`,`p2` = 0.
  - `out_row`==IMG_H-1 → `p6`,`p7`,`p8` = 0.
  - `out_col`==0 → `p0`,`p3`,`p6` = 0.
  - `out_col`==IMG_W-1 → `p2`,`p5`,`p8` = 0.
  - The masks also hide line-buffer contents left from the previous frame or a reset; the buffers are never cleared.
- **Output.** `win_valid` is set by an emitting step. It is cleared when `win_ready` is high and no emitting step occurs in the same cycle. If a new emitting step and `win_ready` coincide, the register reloads and `win_valid` stays 1.
- **win_last** is registered with the window and is 1 only for centre (IMG_H-1, IMG_W-1).
- **Reset** (asynchronous, any time, including mid-frame or mid-FLUSH):
  - State returns to FILL and all counters are zeroed.
  - `win_valid`=0, `win_last`=0, `p0`..`p8`=0.
  - The partial frame is discarded and the next accepted pixel is index 0.
  - `in_ready` is 1 in the first cycle after reset release.

## Timing
- `win_valid` rises one cycle after the emitting step, because the output is registered.
- First window: appears one cycle after accepting index IMG_W+1. This is a latency of IMG_W+2 accepts plus 1 cycle.
- Throughput: 1 window per cycle with no backpressure. A frame takes IMG_W*IMG_H accepts plus IMG_W+1 flush cycles.
- Gaps in `in_valid` stall the pipeline and do not emit anything.
- Backpressure: with `win_ready` low, the window holds stable and `in_ready` is 0.

## Structure
- Package `sobel_pkg`: `PIX_W` default, state enum {FILL, RUN, FLUSH}, and a 3x3 window struct typedef.
- Sub-module `sobel_line_buffer`: a depth-IMG_W delay line with an enable. It is instantiated twice, as a circular-pointer memory or shift register.
- Counters, FSM, masks and output register live in the top level.

## Test plan
- **Ramp frame.** IMG_W=IMG_H=4, pixels 1..16 continuous → exactly 16 windows.
  - Centre 0: 0,0,0,0,1,2,0,5,6.
  - Centre 5: 1,2,3,5,6,7,9,10,11.
  - Centre 15: 11,12,0,15,16,0,0,0,0, with `win_last`=1.
- **Backpressure.** Ramp frame with `win_ready` toggled 1-0-0-1 → the held window stays stable, `in_ready`=0 while held, and the window sequence is identical to the ramp frame case.
- **Input gaps.** `in_valid` at 50% random duty → same 16 windows, same order, and no `win_valid` without a step.
- **Back-to-back frames.** Two 4x4 frames, the second with values 101..116 → the second frame's centre 0 is 0,0,0,0,101,102,0,105,106, with no leakage from frame 1.
- **Mid-frame reset.** Reset after 7 accepted pixels → outputs are 0 during reset, and the following full frame produces the ramp-frame windows.
- **Full-size run.** 512x512 frame → 262144 windows, `win_last` exactly once, and FLUSH takes 513 cycles with `in_ready`=0.
